// File: rtl/bus_master_arbiter.sv
// Two-master, one-slave ECO32 bus arbiter.
// Same-cycle grant, ownership locked across slave wait states.
module bus_master_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0Enable,
  input  logic [1:0]  m0Size,
  input  logic        m0Write,
  input  logic [31:0] m0Address,
  input  logic [31:0] m0WriteData,
  output logic [31:0] m0ReadData,
  output logic        m0Wait,
  input  logic        m1Enable,
  input  logic [1:0]  m1Size,
  input  logic        m1Write,
  input  logic [31:0] m1Address,
  input  logic [31:0] m1WriteData,
  output logic [31:0] m1ReadData,
  output logic        m1Wait,
  output logic        busEnable,
  output logic [1:0]  busSize,
  output logic        busWrite,
  output logic [31:0] busAddress,
  output logic [31:0] busWriteData,
  input  logic [31:0] busReadData,
  input  logic        busWait,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED0 = 2'd1,
    LOCKED1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;

  logic win_valid;
  logic win;
  logic win_en;

  always_comb begin
    win_valid = 1'b0;
    win       = 1'b0;
    unique case (1'b1)
      state_q == LOCKED0: begin
        win_valid = 1'b1;
        win       = 1'b0;
      end
      state_q == LOCKED1: begin
        win_valid = 1'b1;
        win       = 1'b1;
      end
      default: begin
        win_valid = m0Enable | m1Enable;
        if (m0Enable && m1Enable)
          win = FIXED_PRIORITY ? 1'b0 : ~last_q;
        else
          win = m1Enable;
      end
    endcase
  end

  assign win_en = win ? m1Enable : m0Enable;

  always_comb begin
    busEnable    = 1'b0;
    busSize      = 2'b00;
    busWrite     = 1'b0;
    busAddress   = 32'h0;
    busWriteData = 32'h0;
    m0ReadData   = 32'h0;
    m1ReadData   = 32'h0;
    m0Wait       = 1'b0;
    m1Wait       = 1'b0;
    owner        = 2'b00;
    if (reset) begin
      m0Wait = m0Enable;
      m1Wait = m1Enable;
      if (win_valid && !win) begin
        busEnable    = m0Enable;
        busSize      = m0Size;
        busWrite     = m0Write;
        busAddress   = m0Address;
        busWriteData = m0WriteData;
        m0ReadData   = busReadData;
        m0Wait       = m0Enable & busWait;
        owner        = 2'b01;
      end else if (win_valid && win) begin
        busEnable    = m1Enable;
        busSize      = m1Size;
        busWrite     = m1Write;
        busAddress   = m1Address;
        busWriteData = m1WriteData;
        m1ReadData   = busReadData;
        m1Wait       = m1Enable & busWait;
        owner        = 2'b10;
      end
    end
  end

  // Completion and a dropped request both return to IDLE;
  // only completion updates the round-robin pointer.
  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    if (win_valid && win_en) begin
      if (busWait)
        state_d = win ? LOCKED1 : LOCKED0;
      else
        last_d = win;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule
